// File: rtl/spectrum_pkg.sv
// Shared spectrum-analyser definitions: half-buffer sizing and the writer state encoding,
// used by aud_buffer_writer, CoDec_IF and the top level.
package spectrum_pkg;

  localparam int BUFFER_ADDR_BITS_DEF = 9;
  localparam int SMP_BYTE_W           = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_ACK  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/aud_sample_conv.sv
// Reduces a signed audio sample to one RAM byte by truncation to its top 8 bits.
// AUD_BUFF_OFFSET_BINARY_EN selects offset-binary output (MSB inverted) instead of two's complement.
module aud_sample_conv
  import spectrum_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]   smp_data,
  output logic [SMP_BYTE_W-1:0] smp_byte
);

  logic [SMP_BYTE_W-1:0] top_s;

  assign top_s = smp_data[IN_WIDTH-1 -: SMP_BYTE_W];

`ifdef AUD_BUFF_OFFSET_BINARY_EN
  assign smp_byte = {~top_s[SMP_BYTE_W-1], top_s[SMP_BYTE_W-2:0]};
`else
  assign smp_byte = top_s;
`endif

  // Discarded low-order bits are intentionally dropped, not rounded.
  generate
    if (IN_WIDTH > SMP_BYTE_W) begin : g_low_bits
      logic unused_s;
      assign unused_s = ^smp_data[IN_WIDTH-SMP_BYTE_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/aud_buffer_writer.sv
// Ping-pong audio buffer writer: fills the half not being read by CoDec_IF, then hands it over.
// Sample format controlled by AUD_BUFF_OFFSET_BINARY_EN (see aud_sample_conv).
module aud_buffer_writer
  import spectrum_pkg::*;
#(
  parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEF,
  parameter int IN_WIDTH         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IN_WIDTH-1:0]         smp_data_i,
  input  logic                        smp_valid_i,
  output logic                        smp_ready_o,
  input  logic                        buffer_sel_i,
  output logic [BUFFER_ADDR_BITS:0]   ram_wr_addr_o,
  output logic [SMP_BYTE_W-1:0]       ram_wr_data_o,
  output logic                        ram_wren_o,
  output logic                        buffer_filled_o,
  input  logic                        buffer_empty_i,
  output logic                        buffer_empty_ack_o,
  output logic                        underrun_o
);

  localparam logic [BUFFER_ADDR_BITS-1:0] PTR_LAST = {BUFFER_ADDR_BITS{1'b1}};
  localparam logic [BUFFER_ADDR_BITS-1:0] PTR_ZERO = {BUFFER_ADDR_BITS{1'b0}};
  localparam logic [BUFFER_ADDR_BITS-1:0] PTR_ONE  = BUFFER_ADDR_BITS'(1);

  buf_state_e                  state_r;
  logic [BUFFER_ADDR_BITS-1:0] wr_ptr_r;
  logic                        wr_half_r;
  logic                        ready_r;
  logic                        wren_r;
  logic [BUFFER_ADDR_BITS:0]   addr_r;
  logic [SMP_BYTE_W-1:0]       data_r;
  logic                        filled_r;
  logic                        ack_r;
  logic                        underrun_r;
  logic                        accept_s;
  logic [SMP_BYTE_W-1:0]       conv_byte_s;

  aud_sample_conv #(
    .IN_WIDTH (IN_WIDTH)
  ) u_conv (
    .smp_data (smp_data_i),
    .smp_byte (conv_byte_s)
  );

  // ready_r mirrors (state_r == ST_FILL), so this is the handshake
  assign accept_s = smp_valid_i & ready_r;

  // Writer FSM, write pointer and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_FILL;
      wr_ptr_r   <= PTR_ZERO;
      wr_half_r  <= ~buffer_sel_i;
      ready_r    <= 1'b1;
      wren_r     <= 1'b0;
      addr_r     <= {(BUFFER_ADDR_BITS+1){1'b0}};
      data_r     <= {SMP_BYTE_W{1'b0}};
      filled_r   <= 1'b0;
      ack_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      wren_r <= accept_s;
      if (accept_s) begin
        addr_r   <= {wr_half_r, wr_ptr_r};
        data_r   <= conv_byte_s;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case (state_r)
        ST_FILL: begin
          // CoDec drained its half before ours was ready: starvation is sticky
          if (buffer_empty_i) begin
            underrun_r <= 1'b1;
          end
          if (accept_s && (wr_ptr_r == PTR_LAST)) begin
            state_r  <= ST_FULL;
            ready_r  <= 1'b0;
            filled_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (buffer_empty_i) begin
            state_r  <= ST_ACK;
            filled_r <= 1'b0;
            ack_r    <= 1'b1;
          end
        end
        ST_ACK: begin
          // Halves swap here: target whichever half CoDec is not reading now
          if (!buffer_empty_i) begin
            state_r   <= ST_FILL;
            ack_r     <= 1'b0;
            ready_r   <= 1'b1;
            wr_ptr_r  <= PTR_ZERO;
            wr_half_r <= ~buffer_sel_i;
          end
        end
        default: begin
          state_r   <= ST_FILL;
          wr_ptr_r  <= PTR_ZERO;
          wr_half_r <= ~buffer_sel_i;
          ready_r   <= 1'b1;
          filled_r  <= 1'b0;
          ack_r     <= 1'b0;
        end
      endcase
    end
  end

  assign smp_ready_o        = ready_r;
  assign ram_wren_o         = wren_r;
  assign ram_wr_addr_o      = addr_r;
  assign ram_wr_data_o      = data_r;
  assign buffer_filled_o    = filled_r;
  assign buffer_empty_ack_o = ack_r;
  assign underrun_o         = underrun_r;

endmodule

// File: tb/tb_aud_buffer_writer.sv
// Directed self-checking bench for aud_buffer_writer with 4-sample halves and 16-bit input.
module tb_aud_buffer_writer;
  import spectrum_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] smp_data_i;
  logic        smp_valid_i;
  logic        smp_ready_o;
  logic        buffer_sel_i;
  logic [2:0]  ram_wr_addr_o;
  logic [7:0]  ram_wr_data_o;
  logic        ram_wren_o;
  logic        buffer_filled_o;
  logic        buffer_empty_i;
  logic        buffer_empty_ack_o;
  logic        underrun_o;

  int checks;
  int errors;

  aud_buffer_writer #(
    .BUFFER_ADDR_BITS (2),
    .IN_WIDTH         (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .smp_data_i         (smp_data_i),
    .smp_valid_i        (smp_valid_i),
    .smp_ready_o        (smp_ready_o),
    .buffer_sel_i       (buffer_sel_i),
    .ram_wr_addr_o      (ram_wr_addr_o),
    .ram_wr_data_o      (ram_wr_data_o),
    .ram_wren_o         (ram_wren_o),
    .buffer_filled_o    (buffer_filled_o),
    .buffer_empty_i     (buffer_empty_i),
    .buffer_empty_ack_o (buffer_empty_ack_o),
    .underrun_o         (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle; inputs are changed and outputs sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic sel);
    rst_n          = 1'b0;
    smp_valid_i    = 1'b0;
    buffer_empty_i = 1'b0;
    buffer_sel_i   = sel;
    step();
    rst_n = 1'b1;
  endtask

  // Offer one sample for one edge, then drop valid
  task automatic push(input logic [15:0] d);
    smp_data_i  = d;
    smp_valid_i = 1'b1;
    step();
    smp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    smp_data_i = 16'h0000;
    do_reset(1'b0);
    checks++;
    if ({smp_ready_o, ram_wren_o, buffer_filled_o, buffer_empty_ack_o, underrun_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/wren/fill/ack/und=%b want 10000",
               {smp_ready_o, ram_wren_o, buffer_filled_o, buffer_empty_ack_o, underrun_o});
    end
    checks++;
    if ({ram_wr_addr_o, ram_wr_data_o} !== 11'h000) begin
      errors++;
      $display("FAIL reset_addr_data: got addr=%h data=%h want 0/00", ram_wr_addr_o, ram_wr_data_o);
    end
  endtask

  task automatic test_fill();
    logic [15:0] din [4];
    logic [7:0]  dexp [4];
    din = '{16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
`ifdef AUD_BUFF_OFFSET_BINARY_EN
    dexp = '{8'h92, 8'h00, 8'hFF, 8'h7F};
`else
    dexp = '{8'h12, 8'h80, 8'h7F, 8'hFF};
`endif
    do_reset(1'b0);
    smp_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp_data_i = din[i];
      step();
      checks++;
      if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'(4 + i) || ram_wr_data_o !== dexp[i]) begin
        errors++;
        $display("FAIL fill_write%0d: got wren=%b addr=%0d data=%h want 1/%0d/%h",
                 i, ram_wren_o, ram_wr_addr_o, ram_wr_data_o, 4 + i, dexp[i]);
      end
      checks++;
      if ({smp_ready_o, buffer_filled_o} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL fill_state%0d: got ready=%b filled=%b", i, smp_ready_o, buffer_filled_o);
      end
    end
    // Valid still high in FULL must not produce a write
    smp_data_i = 16'h5555;
    step();
    checks++;
    if (ram_wren_o !== 1'b0 || ram_wr_addr_o !== 3'd7 || ram_wr_data_o !== dexp[3] || buffer_filled_o !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: got wren=%b addr=%0d data=%h filled=%b want 0/7/%h/1",
               ram_wren_o, ram_wr_addr_o, ram_wr_data_o, buffer_filled_o, dexp[3]);
    end
    smp_valid_i = 1'b0;
  endtask

  // Continues from FULL left by test_fill
  task automatic test_ack();
    buffer_empty_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({buffer_empty_ack_o, buffer_filled_o, smp_ready_o} !== 3'b100) begin
        errors++;
        $display("FAIL ack_high%0d: got ack/filled/ready=%b want 100",
                 i, {buffer_empty_ack_o, buffer_filled_o, smp_ready_o});
      end
    end
    buffer_empty_i = 1'b0;
    buffer_sel_i   = 1'b1;
    step();
    checks++;
    if ({buffer_empty_ack_o, buffer_filled_o, smp_ready_o, underrun_o} !== 4'b0010) begin
      errors++;
      $display("FAIL ack_release: got ack/filled/ready/underrun=%b want 0010",
               {buffer_empty_ack_o, buffer_filled_o, smp_ready_o, underrun_o});
    end
    push(16'h4000);
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL ack_next_half: got wren=%b addr=%0d want 1/0", ram_wren_o, ram_wr_addr_o);
    end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] e0, e1;
`ifdef AUD_BUFF_OFFSET_BINARY_EN
    e0 = 8'h91; e1 = 8'hB3;
`else
    e0 = 8'h11; e1 = 8'h33;
`endif
    do_reset(1'b1);
    push(16'h1100);
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'd0 || ram_wr_data_o !== e0) begin
      errors++;
      $display("FAIL toggle_w0: got wren=%b addr=%0d data=%h want 1/0/%h", ram_wren_o, ram_wr_addr_o, ram_wr_data_o, e0);
    end
    smp_data_i = 16'h5500;
    step();
    checks++;
    if (ram_wren_o !== 1'b0 || ram_wr_addr_o !== 3'd0 || ram_wr_data_o !== e0) begin
      errors++;
      $display("FAIL toggle_idle0: got wren=%b addr=%0d data=%h want 0/0/%h", ram_wren_o, ram_wr_addr_o, ram_wr_data_o, e0);
    end
    push(16'h3300);
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'd1 || ram_wr_data_o !== e1) begin
      errors++;
      $display("FAIL toggle_w1: got wren=%b addr=%0d data=%h want 1/1/%h", ram_wren_o, ram_wr_addr_o, ram_wr_data_o, e1);
    end
    step();
    checks++;
    if (ram_wren_o !== 1'b0 || ram_wr_addr_o !== 3'd1) begin
      errors++;
      $display("FAIL toggle_idle1: got wren=%b addr=%0d want 0/1", ram_wren_o, ram_wr_addr_o);
    end
    push(16'h0000);
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'd2) begin
      errors++;
      $display("FAIL toggle_w2: got wren=%b addr=%0d want 1/2", ram_wren_o, ram_wr_addr_o);
    end
  endtask

  task automatic test_underrun();
    do_reset(1'b0);
    push(16'h0100);
    push(16'h0200);
    buffer_empty_i = 1'b1;
    step();
    buffer_empty_i = 1'b0;
    checks++;
    if ({underrun_o, buffer_empty_ack_o, smp_ready_o} !== 3'b101) begin
      errors++;
      $display("FAIL underrun_set: got und/ack/ready=%b want 101", {underrun_o, buffer_empty_ack_o, smp_ready_o});
    end
    push(16'h0300);
    checks++;
    if (ram_wr_addr_o !== 3'd6 || underrun_o !== 1'b1) begin
      errors++;
      $display("FAIL underrun_w2: got addr=%0d und=%b want 6/1", ram_wr_addr_o, underrun_o);
    end
    push(16'h0400);
    checks++;
    if (ram_wr_addr_o !== 3'd7 || buffer_filled_o !== 1'b1 || underrun_o !== 1'b1 || buffer_empty_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL underrun_complete: got addr=%0d filled=%b und=%b ack=%b want 7/1/1/0",
               ram_wr_addr_o, buffer_filled_o, underrun_o, buffer_empty_ack_o);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset(1'b1);
    push(16'h1000);
    push(16'h2000);
    rst_n          = 1'b0;
    smp_valid_i    = 1'b1;
    buffer_sel_i   = 1'b0;
    buffer_empty_i = 1'b1;
    step();
    checks++;
    if ({ram_wren_o, buffer_filled_o, buffer_empty_ack_o, underrun_o, ram_wr_addr_o, ram_wr_data_o} !== 15'h0000) begin
      errors++;
      $display("FAIL midreset_outputs: got wren=%b fill=%b ack=%b und=%b addr=%0d data=%h want all 0",
               ram_wren_o, buffer_filled_o, buffer_empty_ack_o, underrun_o, ram_wr_addr_o, ram_wr_data_o);
    end
    rst_n          = 1'b1;
    smp_valid_i    = 1'b0;
    buffer_empty_i = 1'b0;
    step();
    checks++;
    if (ram_wren_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nowrite: got wren=%b want 0", ram_wren_o);
    end
    push(16'hAB00);
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'd4) begin
      errors++;
      $display("FAIL midreset_restart: got wren=%b addr=%0d want 1/4", ram_wren_o, ram_wr_addr_o);
    end
  endtask

  task automatic test_sel_flip();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) buffer_sel_i = 1'b1;
      push(16'h0F00);
      checks++;
      if (ram_wren_o !== 1'b1 || ram_wr_addr_o !== 3'(4 + i)) begin
        errors++;
        $display("FAIL selflip_w%0d: got wren=%b addr=%0d want 1/%0d", i, ram_wren_o, ram_wr_addr_o, 4 + i);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    smp_data_i     = 16'h0000;
    smp_valid_i    = 1'b0;
    buffer_sel_i   = 1'b0;
    buffer_empty_i = 1'b0;
    test_reset();
    test_fill();
    test_ack();
    test_valid_toggle();
    test_underrun();
    test_reset_mid_fill();
    test_sel_flip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
